axi_mem_responder: RTL and testbench

- AXI4 slave endpoint that terminates an `AXI_BUS` and drives a single-port synchronous memory (SRAM macro or register array).
- Sits at the leaf end of an interconnect, typically behind an `axi_regslice`.
- Serialises read and write bursts onto one memory port.
- Supports FIXED and INCR bursts, including narrow transfers. WRAP support is the optional feature.

---
 rtl/axi_mem_pkg.sv | 53 +++++
 rtl/axi_bus.sv | 89 ++++++++
 rtl/axi_mem_rfifo.sv | 66 ++++++
 rtl/axi_mem_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// Shared AXI burst/response types and the burst address generator.
// Optional WRAP support is compiled in with AXI_MEM_RESPONDER_WRAP_EN.
package axi_mem_pkg;

  localparam int unsigned AXI_MAX_AW = 64;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  // Address of the beat following addr; reserved type 3 steps like INCR.
  function automatic logic [AXI_MAX_AW-1:0] axi_next_addr(
    input logic [AXI_MAX_AW-1:0] addr,
    input logic [2:0]            size,
    input logic [7:0]            len,
    input logic [1:0]            burst
  );
    logic [AXI_MAX_AW-1:0] step;
    logic [AXI_MAX_AW-1:0] nxt;
`ifdef AXI_MEM_RESPONDER_WRAP_EN
    logic [AXI_MAX_AW-1:0] mask;
`else
    logic                  unused_len;
`endif
    step = AXI_MAX_AW'(1) << size;
    nxt  = addr + step;
`ifdef AXI_MEM_RESPONDER_WRAP_EN
    mask = ((AXI_MAX_AW'(len) + AXI_MAX_AW'(1)) << size) - AXI_MAX_AW'(1);
    if (burst == FIXED) begin
      nxt = addr;
    end else if ((burst == WRAP) &&
                 ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))) begin
      nxt = (addr & ~mask) | ((addr + step) & mask);
    end
`else
    unused_len = ^len;
    if (burst == FIXED) begin
      nxt = addr;
    end
`endif
    return nxt;
  endfunction

endpackage

// File: rtl/axi_bus.sv
// Generic AXI4 bus bundle with Master/Slave modports.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);

  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_mem_rfifo.sv
// Two-entry read-data FIFO between the memory port and the R channel.
module axi_mem_rfifo #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  // Pointer/count update; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave that serialises read/write bursts onto one synchronous memory port.
// WRAP bursts are honoured only when AXI_MEM_RESPONDER_WRAP_EN is defined.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  AXI_BUS.Slave                     master,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int unsigned AW  = $bits(master.aw_addr);
  localparam int unsigned IW  = $bits(master.aw_id);
  localparam int unsigned UW  = $bits(master.b_user);
  localparam int unsigned BW  = $bits(master.w_data);
  localparam int unsigned OFF = $clog2(DATA_WIDTH / 8);

  if (BW != DATA_WIDTH) begin : g_width_chk
    $fatal(1, "axi_mem_responder: bus data width differs from DATA_WIDTH");
  end
  if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_pow2_chk
    $fatal(1, "axi_mem_responder: DATA_WIDTH must be a power of two >= 8");
  end
  if (AW > AXI_MAX_AW) begin : g_aw_chk
    $fatal(1, "axi_mem_responder: address width exceeds 64");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            prio_wr_q, prio_wr_d;
  logic            aw_ready_q, aw_ready_d;
  logic            ar_ready_q, ar_ready_d;
  logic [IW-1:0]   id_q, id_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [8:0]      beat_q, beat_d;
  logic [7:0]      rbeat_q, rbeat_d;
  logic            inflight_q, inflight_d;

  logic [AW-1:0]   acc_addr;
  logic            pop;
  logic [1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic            unused_ok;

  axi_mem_rfifo #(.DATA_WIDTH(DATA_WIDTH)) u_rfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (mem_rdata),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count)
  );

  assign master.aw_ready = aw_ready_q;
  assign master.ar_ready = ar_ready_q;
  assign master.w_ready  = (state_q == WDATA);
  assign master.b_valid  = (state_q == WRESP);
  assign master.b_id     = id_q;
  assign master.b_resp   = OKAY;
  assign master.b_user   = '0;
  assign master.r_valid  = (fifo_count != 2'd0);
  assign master.r_data   = fifo_data;
  assign master.r_id     = id_q;
  assign master.r_resp   = OKAY;
  assign master.r_user   = '0;
  assign master.r_last   = master.r_valid && (rbeat_q == len_q);

  assign unused_ok = ^{master.aw_lock, master.aw_cache, master.aw_prot, master.aw_qos,
                       master.aw_region, master.aw_atop, master.aw_user,
                       master.ar_lock, master.ar_cache, master.ar_prot, master.ar_qos,
                       master.ar_region, master.ar_user, master.w_last, master.w_user};

  // Arbitration, burst sequencing and memory-port drive.
  // The first read beat is issued in the AR handshake cycle itself, straight from
  // the AR fields, so data reaches the R channel two cycles after the handshake.
  always_comb begin
    state_d    = state_q;
    prio_wr_d  = prio_wr_q;
    aw_ready_d = 1'b0;
    ar_ready_d = 1'b0;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    rbeat_d    = rbeat_q;
    inflight_d = 1'b0;
    acc_addr   = addr_q;
    pop        = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_wstrb  = '0;

    unique case (state_q)
      IDLE: begin
        if (ar_ready_q) begin
          if (master.ar_valid) begin
            id_d       = master.ar_id;
            len_d      = master.ar_len;
            size_d     = master.ar_size;
            burst_d    = master.ar_burst;
            acc_addr   = master.ar_addr;
            addr_d     = AW'(axi_next_addr(AXI_MAX_AW'(master.ar_addr), master.ar_size,
                                           master.ar_len, master.ar_burst));
            mem_req    = 1'b1;
            beat_d     = 9'd1;
            rbeat_d    = '0;
            inflight_d = 1'b1;
            state_d    = RDATA;
          end
        end else if (aw_ready_q) begin
          if (master.aw_valid) begin
            id_d    = master.aw_id;
            addr_d  = master.aw_addr;
            len_d   = master.aw_len;
            size_d  = master.aw_size;
            burst_d = master.aw_burst;
            beat_d  = '0;
            state_d = WDATA;
          end
        end else if (master.ar_valid && master.aw_valid) begin
          if (prio_wr_q) begin
            aw_ready_d = 1'b1;
          end else begin
            ar_ready_d = 1'b1;
          end
          prio_wr_d = ~prio_wr_q;
        end else if (master.ar_valid) begin
          ar_ready_d = 1'b1;
        end else if (master.aw_valid) begin
          aw_ready_d = 1'b1;
        end
      end

      WDATA: begin
        if (master.w_valid) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = master.w_data;
          mem_wstrb = master.w_strb;
          addr_d    = AW'(axi_next_addr(AXI_MAX_AW'(addr_q), size_q, len_q, burst_q));
          beat_d    = beat_q + 9'd1;
          if (beat_q == {1'b0, len_q}) begin
            state_d = WRESP;
          end
        end
      end

      WRESP: begin
        if (master.b_ready) begin
          state_d = IDLE;
        end
      end

      RDATA: begin
        pop = master.r_valid && master.r_ready;
        if ((beat_q <= {1'b0, len_q}) &&
            (({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}))) begin
          mem_req    = 1'b1;
          addr_d     = AW'(axi_next_addr(AXI_MAX_AW'(addr_q), size_q, len_q, burst_q));
          beat_d     = beat_q + 9'd1;
          inflight_d = 1'b1;
        end
        if (pop) begin
          rbeat_d = rbeat_q + 8'd1;
          if (rbeat_q == len_q) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    mem_addr = MEM_ADDR_WIDTH'(acc_addr >> OFF);
  end

  // State and burst-context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_wr_q  <= 1'b0;
      aw_ready_q <= 1'b0;
      ar_ready_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      rbeat_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_wr_q  <= prio_wr_d;
      aw_ready_q <= aw_ready_d;
      ar_ready_q <= ar_ready_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      rbeat_q    <= rbeat_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: directed transactions push expectations,
// negedge monitors pop and compare memory-port, B and R activity.
module tb_axi_mem_responder;
  import axi_mem_pkg::*;

  localparam int unsigned DW  = 64;
  localparam int unsigned MAW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) bus ();

  logic           mem_req, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]  mem_rdata = '0;
  logic [DW-1:0]  rd_pend   = '0;

  axi_mem_responder #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk       (clk),
    .rst       (rst),
    .master    (bus),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  // Memory model: returns word address + 1, one cycle after the read request.
  always @(negedge clk) if (mem_req && !mem_we) rd_pend <= DW'(mem_addr) + 64'd1;
  always @(posedge clk) mem_rdata <= rd_pend;

  typedef struct { logic we; logic [MAW-1:0] addr; logic [63:0] data; logic [7:0] strb; } mem_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct { logic [63:0] data; logic last; logic [3:0] id; } r_t;

  mem_t exp_mem[$];
  b_t   exp_b[$];
  r_t   exp_r[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ar_hs_cyc = 0;
  int last_r_cyc = 0;
  int rd_issued = 0;
  int r_popped = 0;
  bit first_pending = 0;
  bit lat_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: compare every DUT output event against the scoreboard.
  always @(negedge clk) begin
    mem_t m;
    b_t   b;
    r_t   r;
    if (!rst) begin
      if (bus.ar_valid && bus.ar_ready) begin
        ar_hs_cyc     = cyc;
        first_pending = 1'b1;
      end
      if (mem_req) begin
        if (!mem_we) rd_issued++;
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected actual=we%0d addr%h required=none", mem_we, mem_addr);
        end else begin
          m = exp_mem.pop_front();
          check("mem_we", 64'(mem_we), 64'(m.we));
          check("mem_addr", 64'(mem_addr), 64'(m.addr));
          if (m.we) begin
            check("mem_wdata", mem_wdata, m.data);
            check("mem_wstrb", 64'(mem_wstrb), 64'(m.strb));
          end
        end
      end
      if (bus.r_valid && bus.r_ready) begin
        r_popped++;
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual=%h required=none", bus.r_data);
        end else begin
          r = exp_r.pop_front();
          check("r_data", bus.r_data, r.data);
          check("r_last", 64'(bus.r_last), 64'(r.last));
          check("r_id", 64'(bus.r_id), 64'(r.id));
          check("r_resp", 64'(bus.r_resp), 64'(OKAY));
          if (lat_en) begin
            if (first_pending) check("r_first_latency", 64'(cyc - ar_hs_cyc), 64'd2);
            else               check("r_beat_gap", 64'(cyc - last_r_cyc), 64'd1);
          end
        end
        first_pending = 1'b0;
        last_r_cyc    = cyc;
      end
      if (mem_req && !mem_we) check("rd_outstanding_le2", 64'((rd_issued - r_popped) <= 2), 64'd1);
      if (bus.b_valid && bus.b_ready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual=id%0d required=none", bus.b_id);
        end else begin
          b = exp_b.pop_front();
          check("b_id", 64'(bus.b_id), 64'(b.id));
          check("b_resp", 64'(bus.b_resp), 64'(b.resp));
          check("b_user", 64'(bus.b_user), 64'd0);
        end
      end
    end
  end

  task automatic push_wr(input logic [MAW-1:0] a, input logic [63:0] d, input logic [7:0] s);
    exp_mem.push_back('{we: 1'b1, addr: a, data: d, strb: s});
  endtask

  task automatic push_rd(input logic [MAW-1:0] a, input logic last, input logic [3:0] id);
    exp_mem.push_back('{we: 1'b0, addr: a, data: 64'd0, strb: 8'd0});
    exp_r.push_back('{data: 64'(a) + 64'd1, last: last, id: id});
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.aw_id = id; bus.aw_addr = a; bus.aw_len = len; bus.aw_size = size; bus.aw_burst = burst;
    bus.aw_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.aw_ready && n < 100);
    checks++;
    if (!bus.aw_ready) begin errors++; $display("FAIL aw_handshake actual=timeout required=ready"); end
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic last);
    int n = 0;
    bus.w_data = d; bus.w_strb = s; bus.w_last = last; bus.w_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.w_ready && n < 100);
    checks++;
    if (!bus.w_ready) begin errors++; $display("FAIL w_handshake actual=timeout required=ready"); end
    @(posedge clk); #1;
    bus.w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.ar_id = id; bus.ar_addr = a; bus.ar_len = len; bus.ar_size = size; bus.ar_burst = burst;
    bus.ar_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.ar_ready && n < 100);
    checks++;
    if (!bus.ar_ready) begin errors++; $display("FAIL ar_handshake actual=timeout required=ready"); end
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_mem.size() + exp_b.size() + exp_r.size()) != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    check({nm, "_drained"}, 64'(exp_mem.size() + exp_b.size() + exp_r.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_handshake_sigs"},
          64'({bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid, mem_req, mem_we}),
          64'd0);
    check({nm, "_ids"}, 64'({bus.b_id, bus.r_id}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
    bus.aw_lock = 1'b0; bus.aw_cache = '0; bus.aw_prot = '0; bus.aw_qos = '0;
    bus.aw_region = '0; bus.aw_atop = '0; bus.aw_user = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_user = '0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b1;
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
    bus.ar_lock = 1'b0; bus.ar_cache = '0; bus.ar_prot = '0; bus.ar_qos = '0;
    bus.ar_region = '0; bus.ar_user = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("post_reset_idle");

    // Single write.
    push_wr(12'h008, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    exp_b.push_back('{id: 4'd5, resp: OKAY});
    send_aw(4'd5, 32'h40, 8'd0, 3'd3, INCR);
    send_w(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
    drain("write_single");

    // INCR read, r_ready held high.
    lat_en = 1'b1;
    for (int i = 0; i < 4; i++) push_rd(MAW'(12'h020 + i), (i == 3), 4'd1);
    send_ar(4'd1, 32'h100, 8'd3, 3'd3, INCR);
    drain("incr_read");
    lat_en = 1'b0;

    // Same read under R back-pressure.
    for (int i = 0; i < 4; i++) push_rd(MAW'(12'h020 + i), (i == 3), 4'd1);
    fork
      send_ar(4'd1, 32'h100, 8'd3, 3'd3, INCR);
      begin
        for (int k = 0; k < 40; k++) begin
          bus.r_ready = pat[k % 4];
          @(posedge clk); #1;
        end
        bus.r_ready = 1'b1;
      end
    join
    drain("backpressure_read");

    // First contested AW+AR pair: read wins.
    push_rd(12'h040, 1'b0, 4'd2);
    push_rd(12'h041, 1'b1, 4'd2);
    push_wr(12'h060, 64'h1111_2222_3333_4444, 8'hFF);
    exp_b.push_back('{id: 4'd3, resp: OKAY});
    fork
      send_ar(4'd2, 32'h200, 8'd1, 3'd3, INCR);
      begin
        send_aw(4'd3, 32'h300, 8'd0, 3'd3, INCR);
        send_w(64'h1111_2222_3333_4444, 8'hFF, 1'b1);
      end
    join
    drain("arb_pair1");

    // Second contested pair: write wins.
    push_wr(12'h0A0, 64'h5555_6666_7777_8888, 8'h0F);
    exp_b.push_back('{id: 4'd6, resp: OKAY});
    push_rd(12'h0C0, 1'b1, 4'd7);
    fork
      send_ar(4'd7, 32'h600, 8'd0, 3'd3, INCR);
      begin
        send_aw(4'd6, 32'h500, 8'd0, 3'd3, INCR);
        send_w(64'h5555_6666_7777_8888, 8'h0F, 1'b1);
      end
    join
    drain("arb_pair2");

    // FIXED narrow write: three byte writes to the same word.
    push_wr(12'h002, 64'h0000_0000_AA00_0000, 8'h08);
    push_wr(12'h002, 64'h0000_0000_BB00_0000, 8'h08);
    push_wr(12'h002, 64'h0000_0000_CC00_0000, 8'h08);
    exp_b.push_back('{id: 4'd9, resp: OKAY});
    send_aw(4'd9, 32'h13, 8'd2, 3'd0, FIXED);
    send_w(64'h0000_0000_AA00_0000, 8'h08, 1'b0);
    send_w(64'h0000_0000_BB00_0000, 8'h08, 1'b0);
    send_w(64'h0000_0000_CC00_0000, 8'h08, 1'b1);
    drain("fixed_narrow");

    // WRAP read.
    lat_en = 1'b1;
`ifdef AXI_MEM_RESPONDER_WRAP_EN
    push_rd(12'd7, 1'b0, 4'd4);
    push_rd(12'd4, 1'b0, 4'd4);
    push_rd(12'd5, 1'b0, 4'd4);
    push_rd(12'd6, 1'b1, 4'd4);
`else
    push_rd(12'd7,  1'b0, 4'd4);
    push_rd(12'd8,  1'b0, 4'd4);
    push_rd(12'd9,  1'b0, 4'd4);
    push_rd(12'd10, 1'b1, 4'd4);
`endif
    send_ar(4'd4, 32'h38, 8'd3, 3'd3, WRAP);
    drain("wrap_read");
    lat_en = 1'b0;

    // Reset mid-burst: stalled read fills the FIFO, then reset abandons it.
    bus.r_ready = 1'b0;
    exp_mem.push_back('{we: 1'b0, addr: 12'h080, data: 64'd0, strb: 8'd0});
    exp_mem.push_back('{we: 1'b0, addr: 12'h081, data: 64'd0, strb: 8'd0});
    send_ar(4'd1, 32'h400, 8'd7, 3'd3, INCR);
    repeat (4) @(posedge clk);
    #1;
    check("stall_r_valid", 64'(bus.r_valid), 64'd1);
    check("stall_mem_q_empty", 64'(exp_mem.size()), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_quiet("mid_burst_reset");
    rst = 1'b0;
    bus.r_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("after_mid_reset");

    // Transaction after reset starts cleanly from IDLE.
    push_wr(12'h010, 64'h0123_4567_89AB_CDEF, 8'hF0);
    exp_b.push_back('{id: 4'd2, resp: OKAY});
    send_aw(4'd2, 32'h80, 8'd0, 3'd3, INCR);
    send_w(64'h0123_4567_89AB_CDEF, 8'hF0, 1'b1);
    drain("post_reset_write");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
